// File: rtl/jt03_wrq_pkg.sv
// -----------------------------------------------------------------------------
// jt03_wrq_pkg
// Shared definitions for the jt03 register-write queue: sequencer state
// encoding, the position of the busy flag in the jt03 status byte and the
// layout of one queued (register, value) entry. Imported by the RTL and by
// the bench so both agree on the encoding.
// -----------------------------------------------------------------------------
package jt03_wrq_pkg;

   // Sequencer states; the numeric encoding is fixed so the bench can decode it.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      A_WR  = 3'd1,
      A_GAP = 3'd2,
      D_WR  = 3'd3,
      D_GAP = 3'd4,
      POLL  = 3'd5
   } wrq_state_e;

   // Bit of jt03.dout that reports the chip is still busy with a write.
   localparam int STATUS_BUSY_BIT = 7;

   // One queued entry as stored in the FIFO word (register in the high byte).
   typedef struct packed {
      logic [7:0] regn;
      logic [7:0] val;
   } wrq_entry_t;

   // True when an 8-bit tick counter has reached the last tick of a phase
   // that lasts 'len' ticks.
   function automatic logic last_tick(input logic [7:0] cnt, input int len);
      return cnt == 8'(len - 1);
   endfunction

endpackage

// File: rtl/jt03_wrq_fifo.sv
// -----------------------------------------------------------------------------
// jt03_wrq_fifo
// Synchronous 16-bit-wide FIFO with show-ahead read, depth 2**AW.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   flush       synchronous clear of contents (wins over push and pop)
//   push, din   write request and data; ignored while full
//   pop         consume the head entry; ignored while empty
//   dout        head entry, valid whenever empty=0
//   level       current occupancy (registered)
//   full, empty occupancy flags derived from the registered level
// -----------------------------------------------------------------------------
module jt03_wrq_fifo #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic [15:0]   din,
   input  logic          pop,
   output logic [15:0]   dout,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);

   localparam int DEPTH = 1 << AW;

   logic [15:0]   mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   level_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign full      = (level_r == (AW+1)'(DEPTH));
   assign empty     = (level_r == (AW+1)'(0));
   assign do_push_s = push && !full && !flush;
   assign do_pop_s  = pop && !empty && !flush;
   assign dout      = mem_r[rd_ptr_r];
   assign level     = level_r;

   // Storage array; data only, no reset needed since level gates validity.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Read/write pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         level_r  <= (AW+1)'(0);
      end else if (flush) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         level_r  <= (AW+1)'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   level_r <= level_r + (AW+1)'(1);
            2'b01:   level_r <= level_r - (AW+1)'(1);
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/jt03_wrq.sv
// -----------------------------------------------------------------------------
// jt03_wrq
// Register-write queue and bus sequencer placed in front of jt03. Host logic
// pushes (register, value) pairs; each pair is replayed on the jt03 CPU bus
// as an address write then a data write, after which the status busy flag is
// polled before the next pair is started.
// Ports:
//   clk, rst_n   system clock (shared with jt03), async active-low reset
//   cen          jt03 clock enable; the sequencer only advances when high
//   flush        synchronous clear of FIFO and sequencer (cen-independent)
//   push_valid   host write request; push_reg/push_val carry the pair
//   push_ready   FIFO not full
//   level        FIFO occupancy
//   busy         FIFO non-empty or sequencer active
//   timeout_err  one-clk pulse when busy polling gives up on an entry
//   jt_din, jt_addr, jt_cs_n, jt_wr_n  registered jt03 CPU bus drive
//   jt_dout      jt03 status byte, bit STATUS_BUSY_BIT = busy
// -----------------------------------------------------------------------------
module jt03_wrq
   import jt03_wrq_pkg::*;
#(
   parameter int AW           = 4,
   parameter int WR_HOLD      = 2,
   parameter int POLL_BUSY    = 1,
   parameter int BUSY_TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          flush,
   input  logic          push_valid,
   output logic          push_ready,
   input  logic [7:0]    push_reg,
   input  logic [7:0]    push_val,
   output logic [AW:0]   level,
   output logic          busy,
   output logic          timeout_err,
   output logic [7:0]    jt_din,
   output logic          jt_addr,
   output logic          jt_cs_n,
   output logic          jt_wr_n,
   input  logic [7:0]    jt_dout
);

   wrq_state_e state_r, state_nx;
   logic [7:0] cnt_r, cnt_nx;
   wrq_entry_t work_r, work_nx;
   logic       cs_n_r, cs_n_nx;
   logic       wr_n_r, wr_n_nx;
   logic       addr_r, addr_nx;
   logic [7:0] din_r, din_nx;
   logic       to_r, to_nx;

   logic       pop_s;
   logic [15:0] fifo_dout_s;
   wrq_entry_t head_s;
   logic       fifo_full_s;
   logic       fifo_empty_s;
   logic       chip_busy_s;
   logic       dout_unused_s;

   assign head_s        = wrq_entry_t'(fifo_dout_s);
   assign chip_busy_s   = jt_dout[STATUS_BUSY_BIT];
   assign dout_unused_s = ^jt_dout[6:0];

   jt03_wrq_fifo #(
      .AW (AW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push_valid),
      .din   ({push_reg, push_val}),
      .pop   (pop_s),
      .dout  (fifo_dout_s),
      .level (level),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   assign push_ready = !fifo_full_s;
   assign busy       = !fifo_empty_s || (state_r != IDLE);

   // Next-state and next-bus-value logic; bus values are computed for the
   // state being entered so they register on the same edge as the state.
   always_comb begin
      state_nx = state_r;
      cnt_nx   = cnt_r;
      work_nx  = work_r;
      cs_n_nx  = cs_n_r;
      wr_n_nx  = wr_n_r;
      addr_nx  = addr_r;
      din_nx   = din_r;
      to_nx    = 1'b0;
      pop_s    = 1'b0;
      if (cen) begin
         case (state_r)
            IDLE: begin
               if (!fifo_empty_s) begin
                  pop_s    = 1'b1;
                  work_nx  = head_s;
                  state_nx = A_WR;
                  cnt_nx   = 8'd0;
                  cs_n_nx  = 1'b0;
                  wr_n_nx  = 1'b0;
                  addr_nx  = 1'b0;
                  din_nx   = head_s.regn;
               end else begin
                  cs_n_nx  = 1'b1;
                  wr_n_nx  = 1'b1;
               end
            end
            A_WR: begin
               if (last_tick(cnt_r, WR_HOLD)) begin
                  state_nx = A_GAP;
                  cnt_nx   = 8'd0;
                  cs_n_nx  = 1'b1;
                  wr_n_nx  = 1'b1;
               end else begin
                  cnt_nx   = cnt_r + 8'd1;
               end
            end
            A_GAP: begin
               state_nx = D_WR;
               cnt_nx   = 8'd0;
               cs_n_nx  = 1'b0;
               wr_n_nx  = 1'b0;
               addr_nx  = 1'b1;
               din_nx   = work_r.val;
            end
            D_WR: begin
               if (last_tick(cnt_r, WR_HOLD)) begin
                  state_nx = D_GAP;
                  cnt_nx   = 8'd0;
                  cs_n_nx  = 1'b1;
                  wr_n_nx  = 1'b1;
               end else begin
                  cnt_nx   = cnt_r + 8'd1;
               end
            end
            D_GAP: begin
               cnt_nx  = 8'd0;
               addr_nx = 1'b0;
               if (POLL_BUSY != 0) begin
                  state_nx = POLL;
                  cs_n_nx  = 1'b0;
                  wr_n_nx  = 1'b1;
               end else begin
                  state_nx = IDLE;
                  cs_n_nx  = 1'b1;
                  wr_n_nx  = 1'b1;
               end
            end
            POLL: begin
               // The first POLL tick only lets the status read settle.
               if ((cnt_r != 8'd0) && !chip_busy_s) begin
                  state_nx = IDLE;
                  cs_n_nx  = 1'b1;
               end else if (last_tick(cnt_r, BUSY_TIMEOUT)) begin
                  state_nx = IDLE;
                  cs_n_nx  = 1'b1;
                  to_nx    = 1'b1;
               end else begin
                  cnt_nx   = cnt_r + 8'd1;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = 8'd0;
               cs_n_nx  = 1'b1;
               wr_n_nx  = 1'b1;
               addr_nx  = 1'b0;
            end
         endcase
      end else begin
         state_nx = state_r;
      end
   end

   // Sequencer state, work registers and registered bus outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= 8'd0;
         work_r  <= '0;
         cs_n_r  <= 1'b1;
         wr_n_r  <= 1'b1;
         addr_r  <= 1'b0;
         din_r   <= 8'd0;
         to_r    <= 1'b0;
      end else if (flush) begin
         state_r <= IDLE;
         cnt_r   <= 8'd0;
         work_r  <= '0;
         cs_n_r  <= 1'b1;
         wr_n_r  <= 1'b1;
         addr_r  <= 1'b0;
         din_r   <= 8'd0;
         to_r    <= 1'b0;
      end else begin
         state_r <= state_nx;
         cnt_r   <= cnt_nx;
         work_r  <= work_nx;
         cs_n_r  <= cs_n_nx;
         wr_n_r  <= wr_n_nx;
         addr_r  <= addr_nx;
         din_r   <= din_nx;
         to_r    <= to_nx;
      end
   end

   assign jt_cs_n     = cs_n_r;
   assign jt_wr_n     = wr_n_r;
   assign jt_addr     = addr_r;
   assign jt_din      = din_r;
   assign timeout_err = to_r;

endmodule

// File: tb/tb_jt03_wrq.sv
module tb_jt03_wrq;
   import jt03_wrq_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cen = 1'b0;
   logic flush = 1'b0;
   logic push_valid = 1'b0;
   logic [7:0] push_reg = 8'd0;
   logic [7:0] push_val = 8'd0;
   logic [7:0] dout1 = 8'd0;
   logic [7:0] dout2 = 8'd0;

   logic       u1_ready, u1_busy, u1_to, u1_addr, u1_cs_n, u1_wr_n;
   logic [4:0] u1_level;
   logic [7:0] u1_din;
   logic       u2_ready, u2_busy, u2_to, u2_addr, u2_cs_n, u2_wr_n;
   logic [4:0] u2_level;
   logic [7:0] u2_din;

   jt03_wrq dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .flush(flush),
      .push_valid(push_valid), .push_ready(u1_ready),
      .push_reg(push_reg), .push_val(push_val),
      .level(u1_level), .busy(u1_busy), .timeout_err(u1_to),
      .jt_din(u1_din), .jt_addr(u1_addr), .jt_cs_n(u1_cs_n), .jt_wr_n(u1_wr_n),
      .jt_dout(dout1)
   );

   jt03_wrq #(.BUSY_TIMEOUT(8)) dut_to (
      .clk(clk), .rst_n(rst_n), .cen(cen), .flush(flush),
      .push_valid(push_valid), .push_ready(u2_ready),
      .push_reg(push_reg), .push_val(push_val),
      .level(u2_level), .busy(u2_busy), .timeout_err(u2_to),
      .jt_din(u2_din), .jt_addr(u2_addr), .jt_cs_n(u2_cs_n), .jt_wr_n(u2_wr_n),
      .jt_dout(dout2)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // cen generator: cen_div=0 -> cen follows cen_hold, else 1 of every cen_div clks.
   int   cen_div = 0;
   logic cen_hold = 1'b1;
   int   phase = 0;
   always @(posedge clk) begin
      #3;
      if (cen_div == 0) cen = cen_hold;
      else begin
         phase = phase + 1;
         cen = ((phase % cen_div) == 0);
      end
   end

   // Scoreboard of expected strobes on the default instance: {addr, din}.
   logic [8:0] exp_q[$];
   int   exp_width = 2;
   int   strobe_cnt = 0;
   int   to1_cnt = 0;
   logic prev_wr = 1'b1;
   logic [8:0] cur;
   logic [8:0] want;
   int   width = 0;

   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         prev_wr = 1'b1;
         width = 0;
      end else begin
         if (u1_to) to1_cnt++;
         if (!u1_wr_n) begin
            if (prev_wr) begin
               strobe_cnt++;
               cur = {u1_addr, u1_din};
               width = 1;
               chk("strobe_cs_low", u1_cs_n, 1'b0);
               chk("strobe_expected", exp_q.size() > 0, 1'b1);
               if (exp_q.size() > 0) begin
                  want = exp_q.pop_front();
                  chk("strobe_data", cur, want);
               end
            end else begin
               width++;
               chk("strobe_stable", {u1_cs_n, u1_addr, u1_din}, {1'b0, cur});
            end
         end else if (!prev_wr && !flush) begin
            chk("strobe_width", width, exp_width);
         end
         prev_wr = u1_wr_n;
      end
   end

   task automatic push_entry(input logic [7:0] r, input logic [7:0] v);
      push_valid = 1'b1;
      push_reg = r;
      push_val = v;
      if (u1_ready && !flush) begin
         exp_q.push_back({1'b0, r});
         exp_q.push_back({1'b1, v});
      end
      @(negedge clk);
      push_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while ((u1_busy || u2_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {u1_busy, u2_busy}, 2'b00);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t;
      int bad;
      int pc;
      int sc;
      logic [4:0] lv;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_cs_n", u1_cs_n, 1'b1);
      chk("rst_wr_n", u1_wr_n, 1'b1);
      chk("rst_addr", u1_addr, 1'b0);
      chk("rst_din", u1_din, 8'h00);
      chk("rst_ready", u1_ready, 1'b1);
      chk("rst_level", u1_level, 5'd0);
      chk("rst_busy", u1_busy, 1'b0);
      chk("rst_timeout", u1_to, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: single entry, no chip busy
      push_entry(8'h28, 8'hF1);
      t = 1;
      while (u1_busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("t1_busy_done", u1_busy, 1'b0);
      chk("t1_latency_le10", t <= 10, 1'b1);
      chk("t1_level", u1_level, 5'd0);
      chk("t1_q_empty", exp_q.size(), 0);
      wait_idle("t1_idle", 50);

      // 2: fill with cen=0, overflow is dropped, then drain in order
      cen_hold = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 16; i++) push_entry(8'(i + 8'h10), 8'(8'hA0 ^ i));
      chk("t2_level_full", u1_level, 5'd16);
      chk("t2_ready_low", u1_ready, 1'b0);
      push_entry(8'hEE, 8'hEE);
      chk("t2_level_after_drop", u1_level, 5'd16);
      chk("t2_q_len", exp_q.size(), 32);
      cen_hold = 1'b1;
      wait_idle("t2_drain", 400);
      chk("t2_level_end", u1_level, 5'd0);
      chk("t2_q_empty", exp_q.size(), 0);

      // 3: chip busy for 20 ticks holds POLL, next entry follows promptly
      dout1 = 8'h80;
      push_entry(8'h30, 8'h11);
      push_entry(8'h31, 8'h22);
      t = 0;
      while (!(!u1_cs_n && u1_wr_n) && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("t3_reach_poll", {u1_cs_n, u1_wr_n}, 2'b01);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!(!u1_cs_n && u1_wr_n && !u1_addr)) bad++;
      end
      chk("t3_hold_poll", bad, 0);
      dout1 = 8'h00;
      t = 0;
      while (u1_wr_n && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("t3_restart_delay", t, 2);
      wait_idle("t3_idle", 100);

      // 4: chip stuck busy on the BUSY_TIMEOUT=8 instance
      dout2 = 8'h80;
      push_entry(8'h40, 8'h55);
      push_entry(8'h41, 8'h66);
      t = 0;
      while (!(!u2_cs_n && u2_wr_n) && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("t4_reach_poll", {u2_cs_n, u2_wr_n}, 2'b01);
      pc = 0;
      while (!u2_to && pc < 50) begin
         if (!u2_cs_n && u2_wr_n) pc++;
         @(negedge clk);
      end
      chk("t4_poll_ticks", pc, 8);
      chk("t4_pulse", u2_to, 1'b1);
      chk("t4_pulse_cs_n", u2_cs_n, 1'b1);
      @(negedge clk);
      chk("t4_pulse_1clk", u2_to, 1'b0);
      t = 0;
      while (u2_wr_n && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("t4_next_entry", {u2_addr, u2_din}, {1'b0, 8'h41});
      dout2 = 8'h00;
      wait_idle("t4_idle", 200);

      // 5: flush during a data write with 5 entries queued
      for (int i = 0; i < 6; i++) push_entry(8'(8'h60 + i), 8'(8'hC0 + i));
      t = 0;
      while (!(u1_addr && !u1_wr_n) && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("t5_in_dwr", {u1_addr, u1_wr_n}, 2'b10);
      chk("t5_level5", u1_level, 5'd5);
      flush = 1'b1;
      push_valid = 1'b1;
      push_reg = 8'h77;
      push_val = 8'h77;
      @(negedge clk);
      flush = 1'b0;
      push_valid = 1'b0;
      exp_q.delete();
      chk("t5_cs_n", u1_cs_n, 1'b1);
      chk("t5_wr_n", u1_wr_n, 1'b1);
      chk("t5_level", u1_level, 5'd0);
      chk("t5_busy", u1_busy, 1'b0);
      sc = strobe_cnt;
      repeat (40) @(negedge clk);
      chk("t5_no_strobe", strobe_cnt, sc);
      chk("t5_level_later", u1_level, 5'd0);

      // 6: cen at 1/4 rate, push accepted while cen=0
      cen_div = 4;
      exp_width = 8;
      repeat (8) @(negedge clk);
      t = 0;
      while (cen && t < 8) begin
         @(negedge clk);
         t++;
      end
      lv = u1_level;
      push_entry(8'h50, 8'h99);
      chk("t6_push_cen0", u1_level, lv + 5'd1);
      push_entry(8'h51, 8'h9A);
      wait_idle("t6_idle", 600);
      chk("t6_q_empty", exp_q.size(), 0);

      chk("dut_no_timeout", to1_cnt, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
